// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: memory/IO bus controller.
//
// Accepts a single read or write request from the CPU controller, latches
// the address, write data and operation, then steers the access either to
// the on-chip RAM (fixed RAM_WAIT wait cycles) or to the IO region (waits
// for io_ack). A one-cycle mio_ready strobe marks completion.
//
// Parameters:
//   RAM_WAIT  RAM wait cycles per access (1..15)
//   IO_BASE   addr[31:28] value selecting the IO region (data accesses only)
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   mem_r, mem_w            read / write request (write wins if both high)
//   cpu_mio                 1 = data access, 0 = instruction fetch
//   addr, cpu_wdata         request address and write data
//   cpu_rdata, mio_ready    read data and completion strobe to the CPU
//   bus_err                 IO timeout flag
//   ram_addr/we/wdata/rdata RAM port (word address = addr[11:2])
//   io_sel/we/wdata/rdata   IO port, io_ack completes the IO access
//
// Optional feature: define MIO_TIMEOUT_EN to abort an IO access after 16
// cycles without io_ack, returning 32'hDEADBEEF with bus_err set.
module mio_bus_ctrl #(
    parameter int unsigned RAM_WAIT = 1,
    parameter logic [3:0]  IO_BASE  = 4'hE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        cpu_mio,
    input  logic [31:0] addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        mio_ready,
    output logic        bus_err,
    output logic [9:0]  ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        io_sel,
    output logic        io_we,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_ACC = 2'd1,
        IO_ACC  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

    state_t      state_q;
    logic [3:0]  wait_q;
    logic        op_we_q;
    logic [9:0]  ram_addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        ram_we_q;
    logic        io_sel_q;
    logic        io_we_q;

    logic        req_d;
    logic        io_region_d;

    // Only addr[31:28] (region) and addr[11:2] (word address) matter.
    logic        addr_unused;
    assign addr_unused = ^{addr[27:12], addr[1:0]};

    always_comb begin
        req_d       = mem_r | mem_w;
        // Instruction fetches always go to RAM regardless of address.
        io_region_d = cpu_mio && (addr[31:28] == IO_BASE);
    end

`ifdef MIO_TIMEOUT_EN
    logic [3:0] tmo_q;
    logic       bus_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            op_we_q    <= 1'b0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            ram_we_q   <= 1'b0;
            io_sel_q   <= 1'b0;
            io_we_q    <= 1'b0;
`ifdef MIO_TIMEOUT_EN
            tmo_q      <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            // Strobes: mio_ready only in DONE, ram_we only in first RAM_ACC cycle.
            ready_q  <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        ram_addr_q <= addr[11:2];
                        wdata_q    <= cpu_wdata;
                        op_we_q    <= mem_w;
`ifdef MIO_TIMEOUT_EN
                        bus_err_q  <= 1'b0;
                        tmo_q      <= '0;
`endif
                        if (io_region_d) begin
                            state_q  <= IO_ACC;
                            io_sel_q <= 1'b1;
                            io_we_q  <= mem_w;
                        end else begin
                            state_q  <= RAM_ACC;
                            wait_q   <= WAIT_INIT;
                            ram_we_q <= mem_w;
                        end
                    end
                end
                RAM_ACC: begin
                    if (wait_q == '0) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        if (!op_we_q) begin
                            rdata_q <= ram_rdata;
                        end
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                IO_ACC: begin
                    if (io_ack) begin
                        state_q  <= DONE;
                        ready_q  <= 1'b1;
                        io_sel_q <= 1'b0;
                        io_we_q  <= 1'b0;
                        if (!op_we_q) begin
                            rdata_q <= io_rdata;
                        end
                    end
`ifdef MIO_TIMEOUT_EN
                    // An ack in the 16th cycle still wins over the timeout.
                    else if (tmo_q == 4'hF) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b1;
                        io_sel_q  <= 1'b0;
                        io_we_q   <= 1'b0;
                        rdata_q   <= 32'hDEAD_BEEF;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign mio_ready = ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = wdata_q;
    assign io_sel    = io_sel_q;
    assign io_we     = io_we_q;
    assign io_wdata  = wdata_q;
`ifdef MIO_TIMEOUT_EN
    assign bus_err   = bus_err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule
